// File: rtl/crc_pkg.sv
// Shared CRC-32 constants, types and FSM state encoding for the dibit-stream
// CRC generator and checker.
package crc_pkg;

  localparam int unsigned FCS_DIBITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CRC_W      = 32;

  localparam logic [CRC_W-1:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [CRC_W-1:0] CRC32_RESIDUE = 32'hC704_DD7B;
  localparam logic [CRC_W-1:0] CRC32_SEED    = 32'hFFFF_FFFF;

  typedef logic [1:0] dibit_t;

  // EVAL/ADD belong to the generator; the checker uses IDLE/FILL/PASS.
  typedef enum logic [2:0] {IDLE, EVAL, ADD, FILL, PASS} crc_state_t;

  // One line beat of the framed dibit stream.
  typedef struct packed {
    dibit_t d;
    logic   sop;
    logic   eop;
  } crc_beat_t;

endpackage

// File: rtl/crc_check_if.sv
// Framed dibit stream into the CRC checker plus its stripped payload output
// and verdict strobes.
//   d/sop/eop                     : line side, driven by the master
//   d_out/sop_out/eop_out         : payload with FCS removed, driven by the slave
//   crc_ok/crc_err                : one-cycle verdict strobes, driven by the slave
interface crc_check_if;
  import crc_pkg::*;

  dibit_t d;
  logic   sop;
  logic   eop;
  dibit_t d_out;
  logic   sop_out;
  logic   eop_out;
  logic   crc_ok;
  logic   crc_err;

  modport master (
    output d, sop, eop,
    input  d_out, sop_out, eop_out, crc_ok, crc_err
  );

  modport slave (
    input  d, sop, eop,
    output d_out, sop_out, eop_out, crc_ok, crc_err
  );

endinterface

// File: rtl/crc32_dibit_step.sv
// Combinational CRC-32 LFSR advance by one dibit, non-reflected, d[0] first.
//   c      : current LFSR value
//   d      : incoming dibit
//   c_next : LFSR value after both bits are shifted in
module crc32_dibit_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC32_POLY
) (
  input  logic [CRC_W-1:0] c,
  input  dibit_t           d,
  output logic [CRC_W-1:0] c_next
);

  logic fb0;
  logic fb1;

  // fb1 is the feedback of the earlier bit, so its polynomial lands one
  // position higher after the second shift.
  assign fb1 = c[31] ^ d[0];
  assign fb0 = c[30] ^ d[1];

  assign c_next = {c[CRC_W-3:0], 2'b00}
                ^ ({CRC_W{fb1}} & {POLY[CRC_W-2:0], 1'b0})
                ^ ({CRC_W{fb0}} & POLY);

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC-32 checker and FCS stripper for the framed dibit stream.
// Holds every dibit for 16 cycles so the trailing FCS never reaches d_out,
// and strobes crc_ok/crc_err together with eop_out.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of crc_check_if (line in, payload/verdict out)
module crc_check
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY    = CRC32_POLY,
  parameter logic [CRC_W-1:0] RESIDUE = CRC32_RESIDUE
) (
  input  logic       clk,
  input  logic       rst,
  crc_check_if.slave bus
);

  crc_beat_t                     beat;
  crc_state_t                    state;
  logic [CNT_W-1:0]              cnt;
  logic [CRC_W-1:0]              crc_q;
  logic [CRC_W-1:0]              c_in;
  logic [CRC_W-1:0]              c_next;
  logic [FCS_DIBITS-1:0][1:0]    dl;
  dibit_t                        head;
  logic                          in_frame;
  logic                          residue_ok;

  dibit_t                        d_out_q;
  logic                          sop_out_q;
  logic                          eop_out_q;
  logic                          crc_ok_q;
  logic                          crc_err_q;

  assign beat = '{d: bus.d, sop: bus.sop, eop: bus.eop};

  // A sop beat restarts the LFSR from the seed, even mid-frame.
  assign c_in       = beat.sop ? CRC32_SEED : crc_q;
  assign in_frame   = (state != IDLE) || beat.sop;
  assign head       = dl[FCS_DIBITS-1];
  assign residue_ok = (c_next == RESIDUE);

  crc32_dibit_step #(.POLY(POLY)) u_step (
    .c      (c_in),
    .d      (beat.d),
    .c_next (c_next)
  );

  // Frame FSM, delay line, LFSR and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      crc_q     <= CRC32_SEED;
      dl        <= '0;
      d_out_q   <= 2'b00;
      sop_out_q <= 1'b0;
      eop_out_q <= 1'b0;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      d_out_q   <= 2'b00;
      sop_out_q <= 1'b0;
      eop_out_q <= 1'b0;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;

      if (in_frame) begin
        crc_q <= c_next;
        dl    <= {dl[FCS_DIBITS-2:0], beat.d};
      end

      unique case (state)
        IDLE: begin
        end
        FILL: begin
          if (beat.sop) begin
            crc_err_q <= 1'b1;
          end else if (cnt == CNT_W'(FCS_DIBITS)) begin
            // 17th dibit releases payload dibit 0; with eop it is also the last.
            d_out_q   <= head;
            sop_out_q <= 1'b1;
            if (beat.eop) begin
              eop_out_q <= 1'b1;
              crc_ok_q  <= residue_ok;
              crc_err_q <= !residue_ok;
              state     <= IDLE;
            end else begin
              state <= PASS;
            end
          end else if (beat.eop) begin
            crc_err_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PASS: begin
          d_out_q <= head;
          if (beat.sop) begin
            eop_out_q <= 1'b1;
            crc_err_q <= 1'b1;
          end else if (beat.eop) begin
            eop_out_q <= 1'b1;
            crc_ok_q  <= residue_ok;
            crc_err_q <= !residue_ok;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new frame starts on sop in any state; sop with eop is a one-dibit runt.
      if (beat.sop) begin
        cnt <= CNT_W'(1);
        if (beat.eop) begin
          crc_err_q <= 1'b1;
          state     <= IDLE;
        end else begin
          state <= FILL;
        end
      end
    end
  end

  assign bus.d_out   = d_out_q;
  assign bus.sop_out = sop_out_q;
  assign bus.eop_out = eop_out_q;
  assign bus.crc_ok  = crc_ok_q;
  assign bus.crc_err = crc_err_q;

endmodule

// File: doc/crc_check.md
# crc_check

Receive-side CRC-32 checker and FCS stripper for the 2-bit (dibit) framed stream. It consumes frames delimited by `sop`/`eop` whose last 16 dibits are the complemented CRC-32 FCS, in the format the transmit CRC appender emits. It forwards the payload with the FCS removed, re-marks `sop_out`/`eop_out` on the payload boundaries, and strobes a good/bad verdict aligned with `eop_out`. It sits directly downstream of the CRC appender in loopback, and after the line deserialiser in the receive path.

## Interface
- `POLY`, default 32'h04C11DB7: CRC-32 generator polynomial, non-reflected.
- `RESIDUE`, default 32'hC704DD7B: required LFSR value after the last FCS dibit.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `d`  in  2  data dibit; `d[0]` is earlier on the line than `d[1]`.
- `sop`  in  1  first dibit of a frame.
- `eop`  in  1  last dibit of a frame, which is the last FCS dibit.
- `d_out`  out  2  payload dibit; valid from `sop_out` through `eop_out`.
- `sop_out`  out  1  first payload dibit.
- `eop_out`  out  1  last payload dibit.
- `crc_ok`  out  1  1-cycle strobe: frame passed the residue check.
- `crc_err`  out  1  1-cycle strobe: residue mismatch, runt frame, or aborted frame.

## Operation
- **Frame length and contiguity.**
  - L is the frame length in dibits, counted from `sop` to `eop` inclusive.
  - The payload length is P = L-16.
  - A frame is contiguous: one dibit per cycle from `sop` to `eop`.
- **CRC LFSR.**
  - Same update as the generator: `fb0 = c[30]^d[1]`, `fb1 = c[31]^d[0]`, two bits per cycle.
  - On a `sop` dibit, the update uses seed 32'hFFFF_FFFF rather than the held `c`.
  - Every in-frame dibit, including all FCS dibits, is clocked in.
- **Check.** The next LFSR value computed on the `eop` dibit is compared against `RESIDUE`:
  - equal gives `crc_ok`;
  - otherwise `crc_err`.
- **Stripping.**
  - A 16-entry dibit delay line is written every in-frame cycle.
  - Input dibit j is emitted only once dibit j+16 has arrived. The FCS therefore never appears on `d_out`.
- **FSM states:** IDLE, FILL, PASS.
  - IDLE → FILL on `sop`. The 5-bit in-frame count `cnt` is set to 1 and the LFSR is seeded.
  - FILL: `cnt` increments. When `cnt`==16 and a dibit arrives without `eop`, go to PASS. That arrival is the one that releases payload dibit 0.
  - FILL with `eop` is a runt frame (L ≤ 16). Raise `crc_err` only: no `sop_out`, no `eop_out`. Go to IDLE.
  - PASS: emit one payload dibit per cycle. On `eop`, raise `eop_out` with the verdict and go to IDLE.
- **Boundary cases.**
  - `sop` and `eop` in the same cycle: treated as a runt (L=1), `crc_err`.
  - `sop` while in FILL or PASS aborts the current frame:
    - In PASS, `eop_out` and `crc_err` are raised next cycle; `d_out` is the delay-line head.
    - In FILL, `crc_err` only.
    - The `sop` dibit starts a new frame in the same cycle.
  - `eop` in IDLE without `sop`: ignored; no strobes.
  - L=17: `sop_out` and `eop_out` in the same cycle.
  - No maximum length; `cnt` saturates at 16.
  - `rst` mid-frame: frame dropped, FSM to IDLE, no `eop_out` or strobes afterwards.

## Timing
- Reset values: `d_out`=2'b00, `sop_out`=0, `eop_out`=0, `crc_ok`=0, `crc_err`=0; FSM in IDLE.
- Latency. With `sop` at cycle t0:
  - `sop_out` at t0+17;
  - payload dibit j at t0+17+j;
  - `eop_out` and the verdict strobe at t0+L.
- Runt frame: `crc_err` at t0+L, one cycle after input `eop`.
- `crc_ok` and `crc_err` are never high in the same cycle. Exactly one of them pulses per frame that starts with `sop`.
- All outputs are registered.
- Back-to-back frames are supported: `sop` may arrive in the cycle right after `eop`.

## Structure
- Shared package `crc_pkg` holds:
  - `CRC32_POLY`, `CRC32_RESIDUE`, `FCS_DIBITS` = 16;
  - the `crc_state_t` enum {IDLE, EVAL, ADD, FILL, PASS}.
- The generator and `crc_check` both import `crc_pkg`.
- One sub-module, `crc32_dibit_step`: a combinational next-state function (c, d → c_next) instantiated by both the generator and the checker.

## Test plan
- **Good frame.** Payload dibits 0,1,2,3 (L=20) driven through the CRC appender into `crc_check`:
  - `sop_out` at t0+17 and `d_out` 0,1,2,3 at t0+17..t0+20;
  - `eop_out` and `crc_ok` at t0+20.
- **Corrupted FCS.** Same frame with `d[0]` of FCS dibit 5 inverted: identical payload out, `crc_err` at t0+20, `crc_ok` stays 0.
- **Runt.** L=10 (`sop` at t0, `eop` at t0+9): `crc_err` at t0+10; `sop_out`/`eop_out` never asserted.
- **Boundary lengths.** L=17 gives `sop_out`=`eop_out`=1 at t0+17. Back-to-back 20-dibit frames give two `crc_ok` pulses 20 cycles apart.
- **Abort.** `sop` at t0+25 inside a 40-dibit frame: `eop_out`+`crc_err` at t0+26; the new frame gives `sop_out` at t0+42.
- **Reset.** `rst` asserted for 1 cycle at t0+18 of a good frame: all outputs 0 from t0+19; no `eop_out` or strobes afterwards.
